// File: rtl/user_wdt_ctrl.sv
// User-domain watchdog: OBI register file plus a countdown FSM that barks (irq)
// on the first timeout and bites (sticky reset request) on the second.
module user_wdt_ctrl #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter logic [31:0] KickKey   = 32'h5A5A_A5A5,
    parameter logic [31:0] ResetLoad = 32'd1_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [AddrWidth-1:0] obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [3:0]           obi_be_i,
    input  logic [DataWidth-1:0] obi_wdata_i,
    input  logic [IdWidth-1:0]   obi_aid_i,
    output logic                 obi_rvalid_o,
    output logic [DataWidth-1:0] obi_rdata_o,
    output logic                 obi_err_o,
    output logic [IdWidth-1:0]   obi_rid_o,
    output logic                 irq_o,
    output logic                 rst_req_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BARK = 2'd2, BITE = 2'd3} state_e;

    localparam logic [9:0] OFF_CTRL   = 10'h000;
    localparam logic [9:0] OFF_LOAD   = 10'h001;
    localparam logic [9:0] OFF_KICK   = 10'h002;
    localparam logic [9:0] OFF_COUNT  = 10'h003;
    localparam logic [9:0] OFF_STATUS = 10'h004;
    localparam logic [9:0] OFF_STATE  = 10'h005;

    state_e               state_q, state_d;
    logic                 ctrl_en_q, ctrl_lock_q;
    logic [DataWidth-1:0] load_q, count_q, count_d;
    logic                 status_bark_q, status_bite_q;
    logic                 set_bark, set_bite;

    logic                 rvalid_q, err_q;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [IdWidth-1:0]   rid_q;

    logic                 acc_err, ctrl_wr, load_wr, kick_wr, status_wr;
    logic                 kick_good, kick_bad, disable_wr, count_zero;
    logic [9:0]           offset;
    logic                 unused_addr_bits;

    assign offset           = obi_addr_i[11:2];
    assign unused_addr_bits = ^{obi_addr_i[AddrWidth-1:12], obi_addr_i[1:0]};
    assign obi_gnt_o        = obi_req_i;

    // Register decode; every write strobe is qualified by a clean, error-free access.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        acc_err   = 1'b0;
        rdata_d   = '0;
        ctrl_wr   = 1'b0;
        load_wr   = 1'b0;
        kick_wr   = 1'b0;
        status_wr = 1'b0;
        if (obi_req_i) begin
            case (offset)
                OFF_CTRL:
                    if (obi_we_i) begin
                        if (ctrl_lock_q) acc_err = 1'b1;
                        else             ctrl_wr = 1'b1;
                    end else begin
                        rdata_d = {{(DataWidth-2){1'b0}}, ctrl_lock_q, ctrl_en_q};
                    end
                OFF_LOAD:
                    if (obi_we_i) begin
                        if (ctrl_lock_q) acc_err = 1'b1;
                        else             load_wr = 1'b1;
                    end else begin
                        rdata_d = load_q;
                    end
                OFF_KICK:
                    if (obi_we_i) kick_wr = 1'b1;
                OFF_COUNT:
                    if (obi_we_i) acc_err = 1'b1;
                    else          rdata_d = count_q;
                OFF_STATUS:
                    if (obi_we_i) begin
                        if (obi_wdata_i[1]) acc_err   = 1'b1;
                        else                status_wr = 1'b1;
                    end else begin
                        rdata_d = {{(DataWidth-2){1'b0}}, status_bite_q, status_bark_q};
                    end
                OFF_STATE:
                    if (obi_we_i) acc_err = 1'b1;
                    else          rdata_d = {{(DataWidth-2){1'b0}}, state_q};
                default: acc_err = 1'b1;
            endcase
            if (obi_we_i && obi_be_i != 4'hF) begin
                acc_err   = 1'b1;
                ctrl_wr   = 1'b0;
                load_wr   = 1'b0;
                kick_wr   = 1'b0;
                status_wr = 1'b0;
            end
        end
    end

    assign kick_good  = kick_wr && (obi_wdata_i == KickKey);
    assign kick_bad   = kick_wr && (obi_wdata_i != KickKey);
    assign disable_wr = ctrl_wr && !obi_wdata_i[0];
    assign count_zero = (count_q == '0);

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; a valid kick outranks a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ctrl_en_q && !disable_wr) state_d = RUN;
            RUN: begin
                if (disable_wr)                   state_d = IDLE;
                else if (kick_good)               state_d = RUN;
                else if (kick_bad || count_zero)  state_d = BARK;
            end
            BARK: begin
                if (disable_wr)                   state_d = IDLE;
                else if (kick_good)               state_d = RUN;
                else if (kick_bad || count_zero)  state_d = BITE;
            end
            default: state_d = BITE;
        endcase
    end

    // Counter and status actions; reloads always use the pre-edge LOAD value.
    always_comb begin
        count_d  = count_q;
        set_bark = 1'b0;
        set_bite = 1'b0;
        case (state_q)
            IDLE: if (state_d == RUN) count_d = load_q;
            RUN: begin
                if (disable_wr)                    count_d = count_q;
                else if (kick_good)                count_d = load_q;
                else if (kick_bad || count_zero) begin
                    set_bark = 1'b1;
                    count_d  = load_q;
                end else                           count_d = count_q - DataWidth'(1);
            end
            BARK: begin
                if (disable_wr)                    count_d = count_q;
                else if (kick_good)                count_d = load_q;
                else if (kick_bad || count_zero) begin
                    set_bite = 1'b1;
                    count_d  = '0;
                end else                           count_d = count_q - DataWidth'(1);
            end
            default: count_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_en_q     <= 1'b0;
            ctrl_lock_q   <= 1'b0;
            load_q        <= ResetLoad;
            count_q       <= '0;
            status_bark_q <= 1'b0;
            status_bite_q <= 1'b0;
            rvalid_q      <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            rid_q         <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en_q   <= obi_wdata_i[0];
                ctrl_lock_q <= obi_wdata_i[1];
            end
            if (load_wr) load_q <= obi_wdata_i;
            count_q       <= count_d;
            status_bark_q <= set_bark || (status_bark_q && !(status_wr && obi_wdata_i[0]));
            status_bite_q <= status_bite_q || set_bite;
            rvalid_q      <= obi_req_i;
            err_q         <= acc_err;
            rdata_q       <= rdata_d;
            rid_q         <= obi_aid_i;
        end
    end

    assign obi_rvalid_o = rvalid_q;
    assign obi_err_o    = err_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_rid_o    = rid_q;
    assign irq_o        = status_bark_q;
    assign rst_req_o    = status_bite_q;

endmodule

// File: tb/tb_user_wdt_ctrl.sv
// Self-checking bench for user_wdt_ctrl: OBI responses are scoreboarded,
// watchdog timing and escalation are checked against cycle-exact expectations.
module tb_user_wdt_ctrl;

    localparam logic [31:0] KEY = 32'h5A5A_A5A5;
    localparam logic [11:0] A_CTRL = 12'h000, A_LOAD = 12'h004, A_KICK = 12'h008;
    localparam logic [11:0] A_COUNT = 12'h00C, A_STATUS = 12'h010, A_STATE = 12'h014;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        obi_req_i = 1'b0;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i = '0;
    logic        obi_we_i = 1'b0;
    logic [3:0]  obi_be_i = 4'hF;
    logic [31:0] obi_wdata_i = '0;
    logic        obi_aid_i = 1'b0;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic        obi_rid_o;
    logic        irq_o;
    logic        rst_req_o;

    user_wdt_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_aid_i    (obi_aid_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rdata_o  (obi_rdata_o),
        .obi_err_o    (obi_err_o),
        .obi_rid_o    (obi_rid_o),
        .irq_o        (irq_o),
        .rst_req_o    (rst_req_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        logic        rid;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic aid_next = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One OBI transaction; the expected response is queued when the request is driven.
    task automatic obi_txn(input string tag, input logic we, input logic [11:0] off,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        @(negedge clk_i);
        obi_req_i   = 1'b1;
        obi_we_i    = we;
        obi_addr_i  = {20'h20001, off};
        obi_be_i    = be;
        obi_wdata_i = wdata;
        obi_aid_i   = aid_next;
        e.tag   = tag;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.rid   = aid_next;
        e.cyc   = cyc + 1;
        sb.push_back(e);
        #1 check({tag, "_gnt"}, 32'(obi_gnt_o), 32'd1);
        @(posedge clk_i);
        #1;
        obi_req_i = 1'b0;
        obi_we_i  = 1'b0;
        aid_next  = ~aid_next;
    endtask

    task automatic rd(input string tag, input logic [11:0] off, input logic [31:0] exp, input logic exp_err);
        obi_txn(tag, 1'b0, off, 32'h0, 4'hF, exp, exp_err);
    endtask

    task automatic wr(input string tag, input logic [11:0] off, input logic [31:0] data, input logic exp_err);
        obi_txn(tag, 1'b1, off, data, 4'hF, 32'h0, exp_err);
    endtask

    task automatic wait_out(input bit sel_bite, input int max_cyc);
        int n;
        n = 0;
        while (((sel_bite ? rst_req_o : irq_o) !== 1'b1) && n < max_cyc) begin
            @(posedge clk_i);
            #1;
            n++;
        end
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        obi_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_req", 32'(rst_req_o), 32'd0);
        check("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
        rst_ni = 1'b1;
    endtask

    // Response monitor: pops the scoreboard whenever the DUT produces a response.
    always @(negedge clk_i) begin
        if (obi_rvalid_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_rvalid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_rdata"}, obi_rdata_o, mon_e.rdata);
                check({mon_e.tag, "_err"}, 32'(obi_err_o), 32'(mon_e.err));
                check({mon_e.tag, "_rid"}, 32'(obi_rid_o), 32'(mon_e.rid));
                check({mon_e.tag, "_lat"}, 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1;
        do_reset();

        // Reset values and access errors.
        rd("rst_ctrl",   A_CTRL,   32'd0, 1'b0);
        rd("rst_load",   A_LOAD,   32'd1_000_000, 1'b0);
        rd("rst_kick",   A_KICK,   32'd0, 1'b0);
        rd("rst_count",  A_COUNT,  32'd0, 1'b0);
        rd("rst_status", A_STATUS, 32'd0, 1'b0);
        rd("rst_state",  A_STATE,  32'd0, 1'b0);
        rd("unmapped",   12'h018,  32'd0, 1'b1);
        wr("wr_count",   A_COUNT,  32'd5, 1'b1);
        wr("wr_state",   A_STATE,  32'd1, 1'b1);
        wr("wr_bite",    A_STATUS, 32'd2, 1'b1);
        rd("status_kept", A_STATUS, 32'd0, 1'b0);

        // Free-running timeout: bark 11 cycles after RUN entry, bite 11 after that.
        wr("load10", A_LOAD, 32'd10, 1'b0);
        wr("en", A_CTRL, 32'd1, 1'b0);
        c0 = cyc;
        @(posedge clk_i);
        #1;
        rd("state_run", A_STATE, 32'd1, 1'b0);
        wait_out(1'b0, 100);
        check("bark_delay", 32'(cyc - c0), 32'd12);
        c1 = cyc;
        wait_out(1'b1, 100);
        check("bite_delay", 32'(cyc - c1), 32'd11);
        rd("state_bite", A_STATE, 32'd3, 1'b0);
        rd("count_bite", A_COUNT, 32'd0, 1'b0);
        rd("status_bite", A_STATUS, 32'd3, 1'b0);
        check("irq_in_bite", 32'(irq_o), 32'd1);
        do_reset();

        // Good kick at COUNT = 3 reloads; disable freezes COUNT.
        wr("load10b", A_LOAD, 32'd10, 1'b0);
        wr("en_b", A_CTRL, 32'd1, 1'b0);
        repeat (7) @(posedge clk_i);
        rd("count_pre_kick", A_COUNT, 32'd4, 1'b0);
        wr("kick_at3", A_KICK, KEY, 1'b0);
        rd("count_reload", A_COUNT, 32'd10, 1'b0);
        check("irq_after_kick", 32'(irq_o), 32'd0);
        wr("disable", A_CTRL, 32'd0, 1'b0);
        rd("state_idle", A_STATE, 32'd0, 1'b0);
        rd("count_frozen", A_COUNT, 32'd9, 1'b0);

        // Bark, good kick keeps irq; W1C clears it.
        wr("load20", A_LOAD, 32'd20, 1'b0);
        wr("en_c", A_CTRL, 32'd1, 1'b0);
        c0 = cyc;
        wait_out(1'b0, 100);
        check("bark_delay20", 32'(cyc - c0), 32'd22);
        wr("kick_in_bark", A_KICK, KEY, 1'b0);
        rd("state_rearm", A_STATE, 32'd1, 1'b0);
        check("irq_held", 32'(irq_o), 32'd1);
        wr("w1c", A_STATUS, 32'd1, 1'b0);
        check("irq_cleared", 32'(irq_o), 32'd0);
        rd("status_clr", A_STATUS, 32'd0, 1'b0);
        wr("disable_c", A_CTRL, 32'd0, 1'b0);

        // LOAD written during the IDLE->RUN reload applies only from the next reload.
        wr("load3", A_LOAD, 32'd3, 1'b0);
        wr("en_d", A_CTRL, 32'd1, 1'b0);
        wr("load7_same", A_LOAD, 32'd7, 1'b0);
        rd("count_old_load", A_COUNT, 32'd3, 1'b0);
        wr("kick_d", A_KICK, KEY, 1'b0);
        rd("count_new_load", A_COUNT, 32'd7, 1'b0);
        wr("disable_d", A_CTRL, 32'd0, 1'b0);

        // Valid kick coinciding with COUNT == 0 wins over escalation.
        wr("en_e", A_CTRL, 32'd1, 1'b0);
        repeat (8) @(posedge clk_i);
        wr("kick_at0", A_KICK, KEY, 1'b0);
        rd("count_at0", A_COUNT, 32'd7, 1'b0);
        check("irq_kick_at0", 32'(irq_o), 32'd0);
        rd("state_at0", A_STATE, 32'd1, 1'b0);
        wr("disable_e", A_CTRL, 32'd0, 1'b0);
        do_reset();

        // LOAD = 0: one-cycle escalation at each stage.
        wr("load0", A_LOAD, 32'd0, 1'b0);
        wr("en_f", A_CTRL, 32'd1, 1'b0);
        c0 = cyc;
        wait_out(1'b0, 50);
        check("bark_load0", 32'(cyc - c0), 32'd2);
        c1 = cyc;
        wait_out(1'b1, 50);
        check("bite_load0", 32'(cyc - c1), 32'd1);
        do_reset();

        // Lock, partial-byte kick, bad kicks escalate.
        wr("load20g", A_LOAD, 32'd20, 1'b0);
        wr("en_lock", A_CTRL, 32'd3, 1'b0);
        wr("lock_clr_en", A_CTRL, 32'd0, 1'b1);
        wr("lock_load", A_LOAD, 32'd5, 1'b1);
        rd("ctrl_locked", A_CTRL, 32'd3, 1'b0);
        rd("load_locked", A_LOAD, 32'd20, 1'b0);
        rd("count_g", A_COUNT, 32'd17, 1'b0);
        obi_txn("kick_be3", 1'b1, A_KICK, KEY, 4'h3, 32'd0, 1'b1);
        rd("count_no_reload", A_COUNT, 32'd15, 1'b0);
        check("irq_pre_bad", 32'(irq_o), 32'd0);
        wr("bad_kick1", A_KICK, 32'h1234_5678, 1'b0);
        check("irq_bad_kick", 32'(irq_o), 32'd1);
        rd("state_bark", A_STATE, 32'd2, 1'b0);
        rd("count_bark_reload", A_COUNT, 32'd19, 1'b0);
        wr("bad_kick2", A_KICK, 32'h1234_5678, 1'b0);
        check("rst_req_bad", 32'(rst_req_o), 32'd1);
        rd("state_bite2", A_STATE, 32'd3, 1'b0);
        wr("kick_in_bite", A_KICK, KEY, 1'b0);
        rd("state_bite3", A_STATE, 32'd3, 1'b0);
        rd("ctrl_en_stuck", A_CTRL, 32'd3, 1'b0);

        // Reset out of BITE restores every register.
        do_reset();
        rd("post_status", A_STATUS, 32'd0, 1'b0);
        rd("post_ctrl", A_CTRL, 32'd0, 1'b0);
        rd("post_load", A_LOAD, 32'd1_000_000, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/user_wdt_ctrl.md
Name: user_wdt_ctrl

Overview:
Watchdog controller for the user-domain watchdog subordinate window (base 0x2000_1000, 4 KiB, demux index UserWatchdog = 2). It is an OBI subordinate. It decodes a small register file, runs a countdown state machine, raises a bark interrupt on the first timeout, and requests a system reset (bite) on the second. It sits behind the user-domain OBI demux and drives one interrupt line and one reset-request line to the SoC.

Parameters:
AddrWidth, 32, OBI address width
DataWidth, 32, OBI data width; fixed at 32
IdWidth, 1, OBI aid/rid width
KickKey, 32'h5A5A_A5A5, only value accepted as a valid kick
ResetLoad, 32'd1_000_000, reset value of LOAD

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; synchronous, active-low
obi_req_i  in  1  OBI request
obi_gnt_o  out  1  OBI grant
obi_addr_i  in  AddrWidth  byte address; only bits [11:2] decoded
obi_we_i  in  1  write enable
obi_be_i  in  4  byte enables; writes are committed only when be = 4'hF
obi_wdata_i  in  DataWidth  write data
obi_aid_i  in  IdWidth  transaction id
obi_rvalid_o  out  1  response valid
obi_rdata_o  out  DataWidth  read data
obi_err_o  out  1  response error
obi_rid_o  out  IdWidth  echoed id
irq_o  out  1  bark interrupt (level)
rst_req_o  out  1  bite reset request (sticky)

Behaviour:
- Reset is synchronous, active-low, on clk_i. All outputs are 0. State = IDLE. COUNT = 0. LOAD = ResetLoad. CTRL = 0. STATUS = 0.
- OBI handshake:
  - obi_gnt_o = obi_req_i, combinational; there are no wait states.
  - Response comes exactly 1 cycle after the grant: rvalid = 1 for one cycle, rid = registered aid.
  - rdata = 0 on writes and on errors.
- Register map (offset):
  - 0x00 CTRL RW: [0] EN, [1] LOCK. LOCK can only be set, and clears only on reset.
  - 0x04 LOAD RW: timeout reload value.
  - 0x08 KICK WO: reads as 0.
  - 0x0C COUNT RO.
  - 0x10 STATUS: [0] BARK (W1C), [1] BITE (RO).
  - 0x14 STATE RO: [1:0] FSM encoding.
- Errors (err = 1, no side effect):
  - unmapped offset;
  - write to COUNT, STATUS[1] or STATE;
  - write to CTRL or LOAD while LOCK = 1;
  - write with be != 4'hF.
- FSM encoding: IDLE = 0, RUN = 1, BARK = 2, BITE = 3.
  - IDLE: when EN goes 1, COUNT <= LOAD and go to RUN next cycle.
  - RUN: COUNT decrements by 1 per cycle. When COUNT == 0, set STATUS.BARK, reload COUNT <= LOAD, go to BARK.
  - BARK: COUNT decrements by 1 per cycle. When COUNT == 0, set STATUS.BITE, go to BITE.
  - BITE: terminal until reset. rst_req_o = 1. COUNT holds at 0.
- Kick (write to KICK, be = F, no error):
  - data == KickKey in RUN or BARK: COUNT <= LOAD, state <= RUN. STATUS.BARK is not cleared by a kick.
  - data != KickKey in RUN or BARK: immediate escalation. From RUN go to BARK (set BARK, COUNT <= LOAD). From BARK go to BITE.
  - Kick in IDLE or BITE: accepted with no effect, err = 0.
- Disable: writing EN = 0 with LOCK = 0 while in RUN or BARK goes to IDLE. COUNT freezes; STATUS is kept.
- Locking: once LOCK = 1, EN cannot be cleared and LOAD is frozen.
- irq_o = STATUS.BARK, registered. It stays asserted until software W1Cs it; W1C in the same cycle as a new bark: set wins.
- rst_req_o = STATUS.BITE.
- Simultaneous events:
  - A valid kick in the same cycle as COUNT == 0 wins: reload, no escalation.
  - A LOAD write in the same cycle as a reload: the reload uses the old LOAD; the new value applies from the next reload.
- LOAD = 0: escalation on the first counting cycle after entry (RUN to BARK in 1 cycle, BARK to BITE in 1 cycle).
- COUNT is unsigned 32-bit and never wraps; decrement is gated at 0.
- Reset asserted mid-count or in BITE: the next edge returns everything to the reset values.

Test Plan:
- Reset, then read all registers. Expected: CTRL = 0, LOAD = 1_000_000, COUNT = 0, STATUS = 0, STATE = 0; each rvalid 1 cycle after gnt, rid echoed.
- Write LOAD = 10, CTRL = 1, no kicks. Expected: STATE = 1; irq_o rises 11 cycles after entering RUN; rst_req_o rises 11 cycles after that; STATE = 3.
- LOAD = 10, EN = 1, write KickKey when COUNT = 3. Expected: COUNT reads 10 on the following cycle, irq_o stays 0.
- Bark, then write KickKey. Expected: STATE = 1, irq_o stays 1. Then W1C STATUS = 1. Expected: irq_o = 0 on the next cycle.
- CTRL = 3 (EN + LOCK), then write CTRL = 0 and LOAD = 5. Expected: both return err = 1; EN stays 1; LOAD unchanged.
- Write KICK = 32'h1234_5678 in RUN. Expected: immediate BARK, irq_o = 1. A second bad kick gives rst_req_o = 1.
- Access offset 0x18. Expected: err = 1, rdata = 0.
- Write KICK with be = 4'h3. Expected: err = 1, no reload.
